// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the MEM->WB skid register.
//   - default datapath widths
//   - write-back select encodings
//   - control state enum
//   - payload struct carried through both slots
//   - wb_mux(): result selection applied to the head entry
package wb_pkg;
  localparam int WB_XLEN    = 32;
  localparam int WB_RADDR_W = 5;
  localparam int WB_WBSEL_W = 2;

  localparam logic [WB_WBSEL_W-1:0] WB_MEM = 2'd0;
  localparam logic [WB_WBSEL_W-1:0] WB_ALU = 2'd1;
  localparam logic [WB_WBSEL_W-1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                  RegWEn;
    logic [WB_WBSEL_W-1:0] WBSel;
    logic [WB_XLEN-1:0]    PCPlus4;
    logic [WB_RADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    Alu_out;
    logic [WB_XLEN-1:0]    Data_Load;
  } payload_t;

  // Encoding 3 is unused and yields zero.
  function automatic logic [WB_XLEN-1:0] wb_mux(input payload_t p);
    case (p.WBSel)
      WB_MEM:  wb_mux = p.Data_Load;
      WB_ALU:  wb_mux = p.Alu_out;
      WB_PC4:  wb_mux = p.PCPlus4;
      default: wb_mux = '0;
    endcase
  endfunction
endpackage

// File: rtl/wb_stage_skid_reg_slot.sv
// wb_slot_reg: one storage slot (payload + valid bit).
//   clk, reset : clock, async active-high reset (payload and valid -> 0)
//   load       : capture d, set valid
//   clr        : clear valid, payload holds
//   d / q      : payload in / out
//   vld        : slot valid
// The payload only changes on load, so an emptied slot keeps its last contents.
module wb_slot_reg
  import wb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     clr,
  input  payload_t d,
  output payload_t q,
  output logic     vld
);
  payload_t pl_q, pl_d;
  logic     vld_q, vld_d;

  always_comb begin
    pl_d  = load ? d : pl_q;
    vld_d = vld_q;
    if (clr)       vld_d = 1'b0;
    else if (load) vld_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pl_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      pl_q  <= pl_d;
      vld_q <= vld_d;
    end
  end

  assign q   = pl_q;
  assign vld = vld_q;
endmodule

// File: rtl/wb_stage_skid_reg.sv
// wb_stage_skid_reg: MEM->WB pipeline register with a 2-entry skid buffer.
//   clk, reset          : clock, async active-high reset
//   in_valid / in_ready : MEM-side handshake; in_ready depends only on state and reset
//   flush               : drop every held entry on the next edge
//   *_in                : instruction payload from MEM
//   out_valid/out_ready : register-file-side handshake on the head entry
//   RegWEn_out, rd_out  : register-file write enable / address (x0 writes suppressed)
//   wb_data             : selected write-back value of the head entry
// Slot M always drives the outputs; slot S catches the one entry that arrives while
// M is stalled, so in_ready can be taken from a flop rather than from out_ready.
module wb_stage_skid_reg
  import wb_pkg::*;
#(
  parameter int XLEN    = WB_XLEN,
  parameter int RADDR_W = WB_RADDR_W,
  parameter int WBSEL_W = WB_WBSEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic               RegWEn_in,
  input  logic [WBSEL_W-1:0] WBSel_in,
  input  logic [XLEN-1:0]    PCPlus4_in,
  input  logic [RADDR_W-1:0] rd_in,
  input  logic [XLEN-1:0]    Alu_out_in,
  input  logic [XLEN-1:0]    Data_Load_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               RegWEn_out,
  output logic [RADDR_W-1:0] rd_out,
  output logic [XLEN-1:0]    wb_data
);
  wb_state_e state_q, state_d;
  payload_t  in_pl, m_pl, s_pl, m_din;
  logic      m_vld, s_vld;
  logic      m_load, m_clr, m_from_s, s_load, s_clr;
  logic      accept, drain;

  assign in_pl = '{RegWEn: RegWEn_in, WBSel: WBSel_in, PCPlus4: PCPlus4_in,
                   rd: rd_in, Alu_out: Alu_out_in, Data_Load: Data_Load_in};

  assign in_ready  = (state_q != TWO) & ~reset;
  assign out_valid = m_vld;
  assign accept    = in_valid & in_ready;
  assign drain     = m_vld & out_ready;

  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_clr    = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    if (flush) begin
      // Flush wins over any accept; a same-cycle drain is simply overtaken.
      m_clr   = 1'b1;
      s_clr   = 1'b1;
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          m_load  = 1'b1;
          state_d = ONE;
        end
        ONE: begin
          if (accept && drain) begin
            m_load = 1'b1;
          end else if (accept) begin
            s_load  = 1'b1;
            state_d = TWO;
          end else if (drain) begin
            m_clr   = 1'b1;
            state_d = EMPTY;
          end
        end
        TWO: if (drain) begin
          m_load   = 1'b1;
          m_from_s = 1'b1;
          s_clr    = 1'b1;
          state_d  = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
    m_din = m_from_s ? s_pl : in_pl;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  wb_slot_reg u_slot_m (
    .clk(clk), .reset(reset), .load(m_load), .clr(m_clr),
    .d(m_din), .q(m_pl), .vld(m_vld)
  );

  wb_slot_reg u_slot_s (
    .clk(clk), .reset(reset), .load(s_load), .clr(s_clr),
    .d(in_pl), .q(s_pl), .vld(s_vld)
  );

  // s_vld mirrors state TWO; kept for visibility in waveforms.
  logic s_vld_unused;
  assign s_vld_unused = s_vld;

  assign RegWEn_out = m_pl.RegWEn & m_vld & (m_pl.rd != '0);
  assign rd_out     = m_pl.rd;
  assign wb_data    = wb_mux(m_pl);
endmodule

// File: tb/tb_wb_stage_skid_reg.sv
module tb_wb_stage_skid_reg;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0;
  logic        RegWEn_in = 1'b0;
  logic [1:0]  WBSel_in = '0;
  logic [31:0] PCPlus4_in = '0, Alu_out_in = '0, Data_Load_in = '0;
  logic [4:0]  rd_in = '0;
  logic        out_valid, out_ready = 1'b0, RegWEn_out;
  logic [4:0]  rd_out;
  logic [31:0] wb_data;

  wb_stage_skid_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .RegWEn_in(RegWEn_in), .WBSel_in(WBSel_in), .PCPlus4_in(PCPlus4_in), .rd_in(rd_in),
    .Alu_out_in(Alu_out_in), .Data_Load_in(Data_Load_in), .out_valid(out_valid),
    .out_ready(out_ready), .RegWEn_out(RegWEn_out), .rd_out(rd_out), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int       errs = 0, checks = 0;
  payload_t mq[$];   // reference FIFO, head = entry expected on the outputs

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic payload_t mk(input logic we, input logic [1:0] sel, input logic [4:0] rd,
                                  input logic [31:0] alu, input logic [31:0] ld,
                                  input logic [31:0] pc4);
    payload_t p;
    p.RegWEn = we; p.WBSel = sel; p.rd = rd;
    p.Alu_out = alu; p.Data_Load = ld; p.PCPlus4 = pc4;
    return p;
  endfunction

  function automatic logic [31:0] exp_wb(input payload_t p);
    if (p.WBSel == 2'd0)      return p.Data_Load;
    else if (p.WBSel == 2'd1) return p.Alu_out;
    else if (p.WBSel == 2'd2) return p.PCPlus4;
    return 32'd0;
  endfunction

  task automatic model_chk(input string tag);
    payload_t h;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      h = mq[0];
      chk({tag, ".wb_data"}, wb_data, exp_wb(h));
      chk({tag, ".rd_out"}, {27'd0, rd_out}, {27'd0, h.rd});
      chk({tag, ".RegWEn_out"}, {31'd0, RegWEn_out}, {31'd0, h.RegWEn && h.rd != 5'd0});
    end else begin
      chk({tag, ".RegWEn_out"}, {31'd0, RegWEn_out}, 32'd0);
    end
  endtask

  // One cycle: drive after negedge, compare against the model, then advance the model at posedge.
  task automatic step(input string tag, input logic iv, input logic ordy, input logic fl,
                      input payload_t p);
    logic acc, drn;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl;
    RegWEn_in = p.RegWEn; WBSel_in = p.WBSel; rd_in = p.rd;
    Alu_out_in = p.Alu_out; Data_Load_in = p.Data_Load; PCPlus4_in = p.PCPlus4;
    #1 model_chk(tag);
    acc = iv && (mq.size() < 2);
    drn = ordy && (mq.size() > 0);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".RegWEn_out"}, {31'd0, RegWEn_out}, 32'd0);
    chk({tag, ".rd_out"}, {27'd0, rd_out}, 32'd0);
    chk({tag, ".wb_data"}, wb_data, 32'd0);
  endtask

  payload_t z;

  initial begin
    z = mk(0, 0, 0, 0, 0, 0);
    // reset state
    #2 chk_zero_outs("reset");
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rel.in_ready", {31'd0, in_ready}, 32'd1);

    // streaming: one entry per cycle, each visible the cycle after accept
    for (int i = 0; i < 4; i++)
      step("stream", 1, 1, 0, mk(1, 1, 5, 32'h10 + i, 32'h0, 32'h0));
    step("stream_end", 0, 1, 0, z);
    step("stream_idle", 0, 1, 0, z);

    // backpressure fills the skid slot, then drains in order
    step("bp_a", 1, 0, 0, mk(1, 1, 3, 32'hA, 0, 0));
    step("bp_b", 1, 0, 0, mk(1, 1, 4, 32'hB, 0, 0));
    step("bp_full", 1, 0, 0, mk(1, 1, 6, 32'hC, 0, 0));
    step("bp_hold", 0, 0, 0, z);
    step("bp_drain_a", 0, 1, 0, z);
    step("bp_drain_b", 0, 1, 0, z);
    step("bp_idle", 0, 1, 0, z);

    // result mux and x0 suppression
    step("mux_ld", 1, 1, 0, mk(1, 0, 7, 32'h1, 32'hDEADBEEF, 32'h2));
    step("mux_pc", 1, 1, 0, mk(1, 2, 8, 32'h1, 32'h3, 32'h104));
    step("mux_3", 1, 1, 0, mk(1, 3, 9, 32'h1, 32'h3, 32'h5));
    step("mux_x0", 1, 1, 0, mk(1, 1, 0, 32'h77, 32'h3, 32'h5));
    @(negedge clk);
    #1 chk("x0.RegWEn_out", {31'd0, RegWEn_out}, 32'd0);
    chk("x0.out_valid", {31'd0, out_valid}, 32'd1);
    step("mux_idle", 0, 1, 0, z);
    step("mux_idle2", 0, 1, 0, z);

    // flush from TWO with a simultaneous offer
    step("fl_a", 1, 0, 0, mk(1, 1, 1, 32'h100, 0, 0));
    step("fl_b", 1, 0, 0, mk(1, 1, 2, 32'h200, 0, 0));
    step("fl_do", 1, 1, 1, mk(1, 1, 3, 32'h300, 0, 0));
    step("fl_after", 1, 1, 0, mk(1, 1, 4, 32'h400, 0, 0));
    step("fl_next", 0, 1, 0, z);
    step("fl_idle", 0, 1, 0, z);

    // async reset in the middle of a cycle while full
    step("rs_a", 1, 0, 0, mk(1, 1, 1, 32'h500, 0, 0));
    step("rs_b", 1, 0, 0, mk(1, 1, 2, 32'h600, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    mq.delete();
    #1 chk_zero_outs("rs_mid");
    @(negedge clk);
    #1 chk("rs_held.in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1 chk("rs_rel.in_ready", {31'd0, in_ready}, 32'd1);
    step("rs_push", 1, 1, 0, mk(1, 1, 11, 32'h700, 0, 0));
    step("rs_see", 0, 1, 0, z);

    // random soak against the FIFO model
    for (int c = 0; c < 10000; c++) begin
      payload_t p;
      p = mk(1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             $urandom, $urandom, $urandom);
      step("soak", $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 63) == 0, p);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
